// File: rtl/dma_dev_endpoint_if.sv
// DMA device-side handshake bundle between dma_dev_endpoint (master) and dma_controller (slave).
// The endpoint issues rqst/rd_wr/num_words/start_addr and answers dma_ack with dev_ack/dev_in.
interface dma_dev_endpoint_if #(
  parameter int ADD_LEN  = 16,
  parameter int DATA_LEN = 16
);
  logic                rqst;
  logic                rd_wr;
  logic [ADD_LEN-1:0]  num_words;
  logic [ADD_LEN:0]    start_addr;
  logic                dev_ack;
  logic [DATA_LEN-1:0] dev_in;
  logic [DATA_LEN-1:0] dev_out;
  logic                dma_ack;
  logic                end_flag;
  logic                error_flag;

  modport master (
    output rqst, rd_wr, num_words, start_addr, dev_ack, dev_in,
    input  dev_out, dma_ack, end_flag, error_flag
  );

  modport slave (
    input  rqst, rd_wr, num_words, start_addr, dev_ack, dev_in,
    output dev_out, dma_ack, end_flag, error_flag
  );
endinterface

// File: rtl/dma_dev_endpoint.sv
// DMA device endpoint: host fills/drains a local buffer and starts transfers; optional DEV_THROTTLE_EN drops dev_ack periodically.
// Latency: rqst one cycle after start, done one cycle after end_flag/error_flag/timeout; buf_rdata one cycle after buf_raddr.
// Backpressure: dev_ack is deasserted once len words have moved (and on throttle cycles); the DMA paces words via dma_ack.
module dma_dev_endpoint #(
  parameter int ADD_LEN         = 16,
  parameter int DATA_LEN        = 16,
  parameter int BUF_AW          = 5,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int THROTTLE_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic [ADD_LEN-1:0]  len,
  input  logic [ADD_LEN:0]    addr,
  input  logic                buf_we,
  input  logic [BUF_AW-1:0]   buf_waddr,
  input  logic [DATA_LEN-1:0] buf_wdata,
  input  logic [BUF_AW-1:0]   buf_raddr,
  output logic [DATA_LEN-1:0] buf_rdata,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [ADD_LEN-1:0]  words_xfer,
  dma_dev_endpoint_if.master  dma
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADD_LEN:0] DEPTH = (ADD_LEN+1)'(2**BUF_AW);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FINISH} state_t;
  state_t state, state_nxt;

  logic [DATA_LEN-1:0] buf_mem [2**BUF_AW];
  logic                rd_wr_q;
  logic [ADD_LEN-1:0]  num_words_q;
  logic [ADD_LEN:0]    start_addr_q;
  logic [ADD_LEN-1:0]  count, count_nxt;
  logic [TW-1:0]       timer;
  logic                overrun, overrun_nxt;
  logic [1:0]          err_nxt;
  logic                in_range;
  logic                len_bad;
  logic                throttled;
  logic [BUF_AW-1:0]   idx;

  assign in_range = count < num_words_q;
  assign len_bad  = {1'b0, len} > DEPTH;
  assign idx      = count[BUF_AW-1:0];

  assign dma.rd_wr      = rd_wr_q;
  assign dma.num_words  = num_words_q;
  assign dma.start_addr = start_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A dma_ack past len is counted as overrun but never moves count or data.
  always_comb begin
    count_nxt   = count;
    overrun_nxt = overrun;
    if (state == XFER && dma.dma_ack) begin
      if (in_range) count_nxt   = count + ADD_LEN'(1);
      else          overrun_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 2'd0;
    case (state)
      IDLE:   if (start) state_nxt = len_bad ? FINISH : REQ;
      REQ:    state_nxt = XFER;
      XFER: begin
        if (dma.error_flag) begin
          state_nxt = FINISH;
          err_nxt   = 2'd1;
        end else if (dma.end_flag) begin
          state_nxt = FINISH;
          err_nxt   = (overrun_nxt || count_nxt != num_words_q) ? 2'd3 : 2'd0;
        end else if (!dma.dma_ack && timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = FINISH;
          err_nxt   = 2'd2;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dma.rqst    = (state == REQ);
    busy        = (state == REQ) || (state == XFER);
    done        = (state == FINISH);
    dma.dev_ack = (state == XFER) && in_range && !throttled;
    dma.dev_in  = (state == XFER && !rd_wr_q && in_range) ? buf_mem[idx] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_wr_q      <= 1'b0;
      num_words_q  <= '0;
      start_addr_q <= '0;
      count        <= '0;
      timer        <= '0;
      overrun      <= 1'b0;
      err_code     <= 2'd0;
      words_xfer   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count    <= '0;
          timer    <= '0;
          overrun  <= 1'b0;
          if (len_bad) begin
            err_code   <= 2'd3;
            words_xfer <= '0;
          end else begin
            err_code     <= 2'd0;
            rd_wr_q      <= dir;
            num_words_q  <= len;
            start_addr_q <= addr;
          end
        end
        XFER: begin
          count   <= count_nxt;
          overrun <= overrun_nxt;
          timer   <= (dma.dma_ack || dma.end_flag) ? '0 : timer + TW'(1);
          if (state_nxt == FINISH) begin
            err_code   <= err_nxt;
            words_xfer <= count_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // DMA read data is written after the host port so it wins an address collision.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[buf_waddr] <= buf_wdata;
    if (state == XFER && rd_wr_q && dma.dma_ack && in_range) buf_mem[idx] <= dma.dev_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) buf_rdata <= '0;
    else       buf_rdata <= buf_mem[buf_raddr];
  end

`ifdef DEV_THROTTLE_EN
  localparam int THW = $clog2(THROTTLE_PERIOD + 1);
  logic [THW-1:0] thr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     thr_cnt <= '0;
    else if (state != XFER)                        thr_cnt <= '0;
    else if (thr_cnt == THW'(THROTTLE_PERIOD - 1)) thr_cnt <= '0;
    else                                           thr_cnt <= thr_cnt + THW'(1);
  end

  assign throttled = (state == XFER) && (thr_cnt == THW'(THROTTLE_PERIOD - 1));
`else
  assign throttled = 1'b0;
`endif
endmodule

// File: tb/tb_dma_dev_endpoint.sv
// Bench for dma_dev_endpoint: behavioural DMA peer with word memory, scoreboard of expected completions.
module tb_dma_dev_endpoint;
  localparam int AL = 16, DL = 16, AW = 5, DEPTH = 32, MEMW = 1024;

  typedef enum int {M_NORM, M_ERR, M_OVR, M_ERRFIN, M_SILENT} mode_t;
  typedef struct { int err; int words; } exp_t;
  typedef struct { int d; int n; int a; } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, dir;
  logic [AL-1:0] len;
  logic [AL:0]   addr;
  logic          buf_we;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [DL-1:0] buf_wdata, buf_rdata;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [AL-1:0] words_xfer;

  dma_dev_endpoint_if #(.ADD_LEN(AL), .DATA_LEN(DL)) bus();

  dma_dev_endpoint #(.ADD_LEN(AL), .DATA_LEN(DL), .BUF_AW(AW), .TIMEOUT_CYCLES(1024), .THROTTLE_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .len(len), .addr(addr),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .busy(busy), .done(done),
    .err_code(err_code), .words_xfer(words_xfer), .dma(bus)
  );

  always #5 clk = ~clk;

  int         vectors = 0, miscompares = 0, done_cnt = 0;
  logic [DL-1:0] mem  [MEMW];
  logic [DL-1:0] bufm [DEPTH];
  exp_t       exp_q[$];
  req_t       req_q[$];
  mode_t      cur_mode = M_NORM;
  int         cur_k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("err_code", err_code, e.err);
          chk("words_xfer", words_xfer, e.words);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic serve();
    req_t r;
    int target, base, words = 0, guard = 0;
    if (req_q.size() == 0) begin
      chk("unexpected_rqst", 1, 0);
      return;
    end
    r = req_q.pop_front();
    chk("rd_wr", bus.rd_wr, r.d);
    chk("num_words", bus.num_words, r.n);
    chk("start_addr", bus.start_addr, r.a);
    base = r.a / 2;
    @(negedge clk);
    chk("rqst_one_cycle", bus.rqst, 0);
    chk("busy_xfer", busy, 1);
    if (cur_mode == M_SILENT) return;
    target = (cur_mode == M_ERR) ? cur_k : r.n;
    while (words < target && guard < 400) begin
      bus.dma_ack = 1'b0;
      bus.dev_out = DL'($urandom);
      if (bus.dev_ack === 1'b1 && $urandom_range(0, 3) != 0) begin
        bus.dma_ack = 1'b1;
        if (r.d == 1) bus.dev_out = mem[base + words];
        else          mem[base + words] = bus.dev_in;
        words++;
      end
      guard++;
      @(negedge clk);
    end
    bus.dma_ack = 1'b0;
    if (cur_mode != M_ERR) chk("dev_ack_at_len", bus.dev_ack, 0);
    if (cur_mode == M_OVR) begin
      bus.dma_ack = 1'b1;
      bus.dev_out = DL'($urandom);
      @(negedge clk);
      bus.dma_ack = 1'b0;
    end
    case (cur_mode)
      M_ERR:    bus.error_flag = 1'b1;
      M_ERRFIN: begin bus.error_flag = 1'b1; bus.end_flag = 1'b1; end
      default:  bus.end_flag = 1'b1;
    endcase
    @(negedge clk);
    bus.error_flag = 1'b0;
    bus.end_flag   = 1'b0;
  endtask

  // DMA peer
  initial begin
    bus.dma_ack = 1'b0; bus.end_flag = 1'b0; bus.error_flag = 1'b0; bus.dev_out = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.rqst === 1'b1) serve();
    end
  end

  task automatic host_write(input int a, input logic [DL-1:0] d);
    buf_we = 1'b1; buf_waddr = AW'(a); buf_wdata = d; bufm[a] = d;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic run_xfer(input int d, input int n, input int a, input mode_t m, input int k);
    int ee, ew, snap, base;
    base = a / 2;
    if (n > DEPTH) begin
      ee = 3; ew = 0;
    end else begin
      req_q.push_back('{d, n, a});
      case (m)
        M_NORM:   begin ee = 0; ew = n; end
        M_ERR:    begin ee = 1; ew = k; end
        M_OVR:    begin ee = 3; ew = n; end
        M_ERRFIN: begin ee = 1; ew = n; end
        default:  begin ee = 2; ew = 0; end
      endcase
      if (d == 1) for (int i = 0; i < ew; i++) bufm[i] = mem[base + i];
      else        for (int i = 0; i < n; i++)  mem[base + i] = ~bufm[i];
    end
    exp_q.push_back('{ee, ew});
    cur_mode = m; cur_k = k;
    snap = done_cnt;
    start = 1'b1; dir = d[0]; len = AL'(n); addr = (AL+1)'(a);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == snap; c++) @(negedge clk);
    if (done_cnt == snap) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
    chk("err_hold", err_code, ee);
    chk("done_pulse", done, 0);
    if (n <= DEPTH) begin
      if (d == 0) begin
        for (int i = 0; i < ew; i++) chk("mem_write", mem[base + i], bufm[i]);
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          buf_raddr = AW'(i);
          @(negedge clk);
          chk("buf_read", buf_rdata, bufm[i]);
        end
      end
    end
  endtask

  initial begin
    int d, n, a, sel, k;
    mode_t m;
    reset = 1'b1; start = 1'b0; dir = 1'b0; len = '0; addr = '0;
    buf_we = 1'b0; buf_waddr = '0; buf_wdata = '0; buf_raddr = '0;
    for (int i = 0; i < MEMW; i++) mem[i] = DL'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_rqst", bus.rqst, 0);
    chk("rst_dev_ack", bus.dev_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_words", words_xfer, 0);
    chk("rst_num_words", bus.num_words, 0);
    chk("rst_start_addr", bus.start_addr, 0);
    chk("rst_rd_wr", bus.rd_wr, 0);
    chk("rst_dev_in", bus.dev_in, 0);
    chk("rst_buf_rdata", buf_rdata, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) host_write(i, DL'($urandom));

    host_write(0, 16'h00A1); host_write(1, 16'h00B2); host_write(2, 16'h00C3); host_write(3, 16'h00D4);
    run_xfer(0, 4, 'h0200, M_NORM, 0);
    chk("mem_0100", mem['h100], 16'h00A1);
    chk("mem_0103", mem['h103], 16'h00D4);
    mem['h180] = 16'h0011; mem['h181] = 16'h0022; mem['h182] = 16'h0033;
    run_xfer(1, 3, 'h0300, M_NORM, 0);
    run_xfer(0, 0, 'h0040, M_NORM, 0);
    run_xfer(1, 32, 'h0400, M_NORM, 0);
    run_xfer(1, 33, 'h0400, M_NORM, 0);
    run_xfer(0, 40, 'h0400, M_NORM, 0);
    run_xfer(0, 8, 'h0100, M_ERR, 3);
    run_xfer(1, 5, 'h0500, M_ERRFIN, 0);
    run_xfer(0, 6, 'h0600, M_OVR, 0);
    run_xfer(1, 6, 'h0620, M_OVR, 0);
    run_xfer(0, 4, 'h0700, M_SILENT, 0);

    for (int t = 0; t < 25; t++) begin
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      n = 0;
      else if (sel == 1) n = DEPTH;
      else if (sel == 2) n = int'($urandom_range(DEPTH + 1, 200));
      else               n = int'($urandom_range(1, DEPTH - 1));
      a = 2 * int'($urandom_range(0, MEMW - 64));
      sel = int'($urandom_range(0, 9));
      k = 0;
      if (sel < 7)                m = M_NORM;
      else if (sel == 7 && n > 0) begin m = M_ERR; k = int'($urandom_range(0, n - 1)); end
      else if (sel == 8)          m = M_OVR;
      else                        m = M_ERRFIN;
      if (d == 0) for (int j = 0; j < 3; j++) host_write(int'($urandom_range(0, DEPTH - 1)), DL'($urandom));
      run_xfer(d, n, a, m, k);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("requests_consumed", req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
